// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencer with lock qualification, retry and failure latch
// Drives the PLL reset, qualifies the synchronized lock flag, and gates the downstream fabric reset.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 50,
  parameter int LOCK_STABLE_CYCLES  = 5000,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int PW = $clog2(RST_PULSE_CYCLES) + 1;
  localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

  localparam logic [PW-1:0] PULSE_LAST   = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAILED
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [SW-1:0] stable_cnt, stable_cnt_nxt;
  logic [TW-1:0] timeout_cnt, timeout_cnt_nxt;
  logic [3:0]    retry_nxt;
  logic          lock_lost_nxt;
  logic          sync_meta, locked_s;
  logic          timeout_hit;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= RESET_PLL;
      pulse_cnt   <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
      retry_count <= '0;
      lock_lost   <= 1'b0;
      sync_meta   <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pulse_cnt   <= pulse_cnt_nxt;
      stable_cnt  <= stable_cnt_nxt;
      timeout_cnt <= timeout_cnt_nxt;
      retry_count <= retry_nxt;
      lock_lost   <= lock_lost_nxt;
      sync_meta   <= pll_locked;
      locked_s    <= sync_meta;
    end
  end

  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

  always_comb begin
    state_nxt       = state;
    pulse_cnt_nxt   = pulse_cnt;
    stable_cnt_nxt  = stable_cnt;
    timeout_cnt_nxt = timeout_cnt;
    retry_nxt       = retry_count;
    lock_lost_nxt   = 1'b0;

    if (relock_req) begin
      state_nxt       = RESET_PLL;
      pulse_cnt_nxt   = '0;
      stable_cnt_nxt  = '0;
      timeout_cnt_nxt = '0;
      retry_nxt       = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (pulse_cnt == PULSE_LAST) begin
            state_nxt       = WAIT_LOCK;
            timeout_cnt_nxt = '0;
          end else begin
            pulse_cnt_nxt = pulse_cnt + PW'(1);
          end
        end
        WAIT_LOCK, STABILIZE: begin
          // The attempt window spans both states, so timeout overrides any lock progress.
          if (timeout_hit) begin
            if (retry_count == RETRY_LIMIT) begin
              state_nxt = FAILED;
            end else begin
              retry_nxt     = retry_count + 4'd1;
              state_nxt     = RESET_PLL;
              pulse_cnt_nxt = '0;
            end
          end else begin
            timeout_cnt_nxt = timeout_cnt + TW'(1);
            if (state == WAIT_LOCK) begin
              if (locked_s) begin
                state_nxt      = STABILIZE;
                stable_cnt_nxt = '0;
              end
            end else if (!locked_s) begin
              state_nxt = WAIT_LOCK;
            end else if (stable_cnt == STABLE_LAST) begin
              state_nxt = RUN;
            end else begin
              stable_cnt_nxt = stable_cnt + SW'(1);
            end
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt     = RESET_PLL;
            pulse_cnt_nxt = '0;
            retry_nxt     = '0;
            lock_lost_nxt = 1'b1;
          end
        end
        FAILED: begin
          state_nxt = FAILED;
        end
        default: begin
          state_nxt     = RESET_PLL;
          pulse_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign pll_rst = (state == RESET_PLL) || (state == FAILED);
  assign sys_rst = (state != RUN);
  assign ready   = (state == RUN);
  assign fail    = (state == FAILED);

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequencer for the HPS-side fabric PLL: generates the PLL reset pulse, qualifies the PLL `locked` flag, and releases the downstream fabric reset only after lock has held continuously for a programmable window. On lock timeout it retries a bounded number of times, then latches a failure. On lock loss during operation it re-asserts the downstream reset and restarts the PLL. It runs on the 50 MHz PLL reference clock and sits between the board reset and the PLL instance and its consumers.

## Interface

Parameters:
- `RST_PULSE_CYCLES`, default 50: PLL reset pulse width in refclk cycles (1 us); must be ≥ 1.
- `LOCK_STABLE_CYCLES`, default 5000: consecutive synchronized-lock cycles required before release (100 us); must be ≥ 1.
- `LOCK_TIMEOUT_CYCLES`, default 50000: per-attempt window, in refclk cycles, to achieve stable lock (1 ms); must be > `LOCK_STABLE_CYCLES`.
- `MAX_RETRIES`, default 3: PLL re-resets after the first attempt before declaring failure; range 0..15.

Ports:
- `refclk`, in, 1: sole clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `pll_locked`, in, 1: PLL lock flag. It is asynchronous to `refclk`.
- `relock_req`, in, 1: single-cycle request to restart the whole sequence.
- `pll_rst`, out, 1: drives the PLL `rst` input.
- `sys_rst`, out, 1: active-high reset for logic clocked by the PLL outputs.
- `ready`, out, 1: high while the PLL is qualified and `sys_rst` is released.
- `fail`, out, 1: high once the retry budget is exhausted.
- `lock_lost`, out, 1: one-cycle pulse when lock drops in RUN.
- `retry_count`, out, 4: number of retries used in the current sequence.

## Operation

- `pll_locked` passes through a 2-flop synchronizer; `locked_s` is the second flop. Synchronizer flops reset to 0.
- FSM states: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAILED. All outputs are registered and decoded from the state register.
  - `pll_rst` = 1 in RESET_PLL and FAILED.
  - `sys_rst` = 1 in every state except RUN.
  - `ready` = 1 in RUN only.
  - `fail` = 1 in FAILED only.
- Reset values: state RESET_PLL, all counters 0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `lock_lost`=0, `retry_count`=0.
- RESET_PLL: the pulse counter runs. When it reaches `RST_PULSE_CYCLES`-1, go to WAIT_LOCK and clear the timeout counter.
- WAIT_LOCK: the timeout counter runs.
  - If `locked_s`=1, go to STABILIZE with the stable counter at 0.
- STABILIZE: the timeout counter keeps running and is not cleared.
  - If `locked_s`=0, return to WAIT_LOCK.
  - When the stable counter reaches `LOCK_STABLE_CYCLES`-1 with `locked_s`=1, go to RUN.
- Timeout (applies in WAIT_LOCK and STABILIZE): when the timeout counter reaches `LOCK_TIMEOUT_CYCLES`-1, the timeout takes priority over lock and stable transitions.
  - If `retry_count`==`MAX_RETRIES`, go to FAILED.
  - Otherwise increment `retry_count` and go to RESET_PLL.
- RUN: if `locked_s`=0, go to RESET_PLL, pulse `lock_lost` for one cycle, and clear `retry_count`.
- FAILED: held until `rst` or `relock_req`. `pll_rst` stays high.
- `relock_req` applies in any state: go to RESET_PLL, clear all counters and `retry_count`. This forces `fail`=0 and `ready`=0 on the next edge.
- Priority: `rst` > `relock_req` > timeout > lock-driven transitions.
- Counters are sized to `$clog2` of their parameter plus 1 and never wrap. `retry_count` never exceeds `MAX_RETRIES`.

## Timing

- After `rst` deasserts, `pll_rst` stays high for exactly `RST_PULSE_CYCLES` edges. It falls on edge `RST_PULSE_CYCLES`, counting the first edge with `rst`=0 as edge 1.
- Once lock is qualified, `ready` rises and `sys_rst` falls on the same edge.
- Lock qualification latency: `ready` rises `LOCK_STABLE_CYCLES`+3 edges after the first edge that samples `pll_locked`=1. That is 2 synchronizer edges, 1 edge to enter STABILIZE, and `LOCK_STABLE_CYCLES` edges in STABILIZE.
- Lock-loss latency: `sys_rst` rises, `ready` falls, `lock_lost` pulses and `pll_rst` rises 3 edges after the first edge that samples `pll_locked`=0.
- An attempt with no lock lasts `RST_PULSE_CYCLES`+`LOCK_TIMEOUT_CYCLES` cycles.
- `relock_req` takes effect on the edge where it is sampled high.
- A `relock_req` coincident with `rst` is ignored, because `rst` wins.

## Test plan

Directed tests use `RST_PULSE_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `MAX_RETRIES`=2.

- **Normal bring-up:** release `rst`, then raise `pll_locked` 6 cycles after `pll_rst` falls -> `pll_rst` high for exactly 4 cycles; `ready`=1 and `sys_rst`=0 exactly 11 edges after `pll_locked` is first sampled high; `retry_count`=0.
- **Glitch in STABILIZE:** drop `pll_locked` for 1 cycle after 5 stable cycles -> no `ready`; the stable count restarts; `ready` rises 11 edges after `pll_locked` returns, provided this is inside the 32-cycle window.
- **Timeout/fail:** hold `pll_locked`=0 -> 3 `pll_rst` pulses at 36-cycle spacing; `retry_count` goes 1 then 2; `fail`=1 at cycle 108; `pll_rst` then stays high.
- **Lock loss in RUN:** from RUN, drop `pll_locked` -> 3 edges later `sys_rst`=1, `ready`=0, `lock_lost` high for exactly 1 cycle, `pll_rst` high for 4 cycles; `retry_count`=0; re-lock brings `ready` back.
- **Recovery from FAILED:** pulse `relock_req` while `fail`=1 -> next edge `fail`=0 and `pll_rst`=1 for 4 cycles; with `pll_locked`=1, `ready` follows. Assert `relock_req` together with `rst` -> reset values only.
- **Chatter:** toggle `pll_locked` with period 10 (5 high, 5 low) -> `ready` never asserts; a retry occurs every 36 cycles; `fail`=1 after the third attempt.
